// File: rtl/threefish_pkg.sv
`default_nettype none
// ============================================================================
// Module      : threefish_pkg
// Description : Shared widths and FSM state encoding for the Threefish
//               requester arbiter.
// Contents    : KEY_W / TWEAK_W / BLK_W operand widths, state_e FSM enum,
//               req_onehot() helper mapping a requester index to a grant.
// Revision    : 1.0 - initial release
// ============================================================================
package threefish_pkg;

  localparam int KEY_W   = 512;
  localparam int TWEAK_W = 128;
  localparam int BLK_W   = 512;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_RESP       = 3'd4
  } state_e;

  // One-hot pattern for a requester index (0 or 1).
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/threefish_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : threefish_arb_grant
// Description : Two-way fixed/rotating priority picker. Produces a one-hot
//               grant among the valid requesters; ptr_i names the requester
//               that wins when both are valid.
// Ports       : valid_i [1:0] requester valids
//               ptr_i         priority requester index
//               gnt_o   [1:0] one-hot grant (all zero when nothing valid)
// Revision    : 1.0 - initial release
// ============================================================================
module threefish_arb_grant (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (!ptr_i) begin
      if (valid_i[0])      gnt_o = 2'b01;
      else if (valid_i[1]) gnt_o = 2'b10;
    end else begin
      if (valid_i[1])      gnt_o = 2'b10;
      else if (valid_i[0]) gnt_o = 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/threefish_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : threefish_arbiter
// Description : Shares one Threefish core between two requesters. A request
//               is accepted in IDLE, its operands are written to the core with
//               a single-cycle strobe triple, the core busy pulse is tracked,
//               and the result is returned to the granted requester only.
//               A core that never raises busy within BUSY_WAIT_MAX cycles sets
//               the sticky outErr flag and the operation is dropped.
// Config      : `define THREEFISH_ARB_RR_EN -> round-robin priority between
//               simultaneous requests; otherwise requester 0 always wins.
// Ports       : inClk/inRstN                clock, async active-low reset
//               inReqValidN/outReqReadyN    request handshake
//               inKeyN/inTweakN/inBlockN    requester operands
//               outRespValidN/inRespReadyN  result handshake, outResp data
//               outCore*Wr, outCore*        core write strobes and operands
//               inCoreBlock, inCoreBusy     core result and busy
//               outErr                      sticky busy-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module threefish_arbiter
  import threefish_pkg::*;
#(
  parameter int BUSY_WAIT_MAX = 15,
  parameter int NREQ          = 2
) (
  input  logic               inClk,
  input  logic               inRstN,
  input  logic               inReqValid0,
  input  logic               inReqValid1,
  output logic               outReqReady0,
  output logic               outReqReady1,
  input  logic [KEY_W-1:0]   inKey0,
  input  logic [KEY_W-1:0]   inKey1,
  input  logic [TWEAK_W-1:0] inTweak0,
  input  logic [TWEAK_W-1:0] inTweak1,
  input  logic [BLK_W-1:0]   inBlock0,
  input  logic [BLK_W-1:0]   inBlock1,
  output logic               outRespValid0,
  output logic               outRespValid1,
  input  logic               inRespReady0,
  input  logic               inRespReady1,
  output logic [BLK_W-1:0]   outResp,
  output logic               outCoreKeyWr,
  output logic               outCoreTweakWr,
  output logic               outCoreBlockWr,
  output logic [KEY_W-1:0]   outCoreKey,
  output logic [TWEAK_W-1:0] outCoreTweak,
  output logic [BLK_W-1:0]   outCoreBlock,
  input  logic [BLK_W-1:0]   inCoreBlock,
  input  logic               inCoreBusy,
  output logic               outErr
);

  // Timeout fires on the BUSY_WAIT_MAX-th WAIT_START cycle without busy.
  localparam int CNT_LAST = (BUSY_WAIT_MAX > 0) ? BUSY_WAIT_MAX - 1 : 0;
  localparam int CNT_W    = (CNT_LAST > 0) ? $clog2(CNT_LAST + 1) : 1;

  generate
    if (NREQ != 2) begin : g_nreq_check
      $error("threefish_arbiter supports NREQ == 2 only");
    end
  endgenerate

  state_e             state_q;
  logic               gnt_id_q;
  logic               prio_q;
  logic               wr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [TWEAK_W-1:0] tweak_q;
  logic [BLK_W-1:0]   blk_q;
  logic [BLK_W-1:0]   resp_q;
  logic [1:0]         resp_vld_q;
  logic               err_q;

  logic [1:0]         req_valid;
  logic [1:0]         gnt_oh;
  logic               idle;

  assign req_valid = {inReqValid1, inReqValid0};
  assign idle      = (state_q == ST_IDLE);

  threefish_arb_grant u_grant (
    .valid_i (req_valid),
    .ptr_i   (prio_q),
    .gnt_o   (gnt_oh)
  );

  // Ready is the acceptance itself, so it must follow valid within the cycle.
  // Gating with inRstN keeps it low while reset is held.
  assign outReqReady0 = inRstN & idle & gnt_oh[0];
  assign outReqReady1 = inRstN & idle & gnt_oh[1];

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= 1'b0;
      prio_q     <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      key_q      <= '0;
      tweak_q    <= '0;
      blk_q      <= '0;
      resp_q     <= '0;
      resp_vld_q <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt_oh) begin
            gnt_id_q <= gnt_oh[1];
            key_q    <= gnt_oh[1] ? inKey1   : inKey0;
            tweak_q  <= gnt_oh[1] ? inTweak1 : inTweak0;
            blk_q    <= gnt_oh[1] ? inBlock1 : inBlock0;
            wr_q     <= 1'b1;   // strobes are high for the whole ISSUE cycle
            state_q  <= ST_ISSUE;
`ifdef THREEFISH_ARB_RR_EN
            prio_q   <= ~gnt_oh[1];
`endif
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (inCoreBusy) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == CNT_W'(CNT_LAST)) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!inCoreBusy) begin
            resp_q     <= inCoreBlock;
            resp_vld_q <= req_onehot(gnt_id_q);
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (gnt_id_q ? inRespReady1 : inRespReady0) begin
            resp_vld_q <= 2'b00;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign outCoreKeyWr   = wr_q;
  assign outCoreTweakWr = wr_q;
  assign outCoreBlockWr = wr_q;
  assign outCoreKey     = key_q;
  assign outCoreTweak   = tweak_q;
  assign outCoreBlock   = blk_q;
  assign outResp        = resp_q;
  assign outRespValid0  = resp_vld_q[0];
  assign outRespValid1  = resp_vld_q[1];
  assign outErr         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_threefish_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_threefish_arbiter
// Description : Directed bench for threefish_arbiter with a behavioural core
//               (programmable busy length, optional "never busy" mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_threefish_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready = 2'b00;
  logic [511:0] key [2];
  logic [127:0] tweak [2];
  logic [511:0] blk [2];
  logic [511:0] outResp;
  logic         wr_key, wr_tw, wr_blk;
  logic [511:0] core_key;
  logic [127:0] core_tweak;
  logic [511:0] core_blk;
  logic [511:0] core_res = '0;
  logic         core_busy = 1'b0;
  logic         outErr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  threefish_arbiter #(.BUSY_WAIT_MAX(15), .NREQ(2)) dut (
    .inClk          (clk),
    .inRstN         (rst_n),
    .inReqValid0    (req_valid[0]),
    .inReqValid1    (req_valid[1]),
    .outReqReady0   (req_ready[0]),
    .outReqReady1   (req_ready[1]),
    .inKey0         (key[0]),
    .inKey1         (key[1]),
    .inTweak0       (tweak[0]),
    .inTweak1       (tweak[1]),
    .inBlock0       (blk[0]),
    .inBlock1       (blk[1]),
    .outRespValid0  (resp_valid[0]),
    .outRespValid1  (resp_valid[1]),
    .inRespReady0   (resp_ready[0]),
    .inRespReady1   (resp_ready[1]),
    .outResp        (outResp),
    .outCoreKeyWr   (wr_key),
    .outCoreTweakWr (wr_tw),
    .outCoreBlockWr (wr_blk),
    .outCoreKey     (core_key),
    .outCoreTweak   (core_tweak),
    .outCoreBlock   (core_blk),
    .inCoreBlock    (core_res),
    .inCoreBusy     (core_busy),
    .outErr         (outErr)
  );

  // Stand-in cipher: any fixed bijective-ish mix of the three operands.
  function automatic logic [511:0] core_f(input logic [511:0] k, input logic [127:0] t,
                                          input logic [511:0] b);
    return ({b[510:0], b[511]} ^ k) + {4{t}};
  endfunction

  // Core model: busy rises one cycle after the strobe and lasts busy_len cycles.
  int   busy_len = 4;
  int   bcnt = 0;
  bit   no_busy = 1'b0;
  bit   start_p = 1'b0;
  int   strobe_cnt = 0;
  int   strobe_bad = 0;
  always @(negedge clk) begin
    if (start_p) begin
      start_p = 1'b0;
      if (!no_busy) begin
        core_busy = 1'b1;
        bcnt = busy_len;
      end
    end else if (core_busy) begin
      bcnt = bcnt - 1;
      if (bcnt == 0) core_busy = 1'b0;
    end
    if (wr_key === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      start_p = 1'b1;
      core_res = core_f(core_key, core_tweak, core_blk);
    end
    if (!(wr_key === wr_tw && wr_tw === wr_blk)) strobe_bad = strobe_bad + 1;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Polls from the current cycle (just after a negedge) for a ready.
  task automatic wait_grant(input int limit, output int who);
    who = -1;
    for (int i = 0; i < limit; i++) begin
      #1;
      if (req_ready !== 2'b00) begin
        who = (req_ready === 2'b11) ? 3 : (req_ready[1] ? 1 : 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  // One operation; with hold=1 it returns while the response is still pending.
  task automatic run_op(input int who, input logic [511:0] k, input logic [127:0] t,
                        input logic [511:0] b, input int blen, input bit hold,
                        output logic [511:0] r, output int lat);
    int g;
    key[who] = k; tweak[who] = t; blk[who] = b; busy_len = blen;
    resp_ready[who] = !hold;
    req_valid[who] = 1'b1;
    wait_grant(50, g);
    check("op_grant", g, who);
    @(negedge clk);
    req_valid[who] = 1'b0;
    lat = 1;
    while (resp_valid[who] !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    r = outResp;
    check("op_resp_valid", resp_valid, (who == 1) ? 2 : 1);
    if (!hold) begin
      @(negedge clk);
      resp_ready[who] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] r, held, exp, cur;
    int           lat, g, sc0;
    int           exp_g [4];
    bit           bad;
`ifdef THREEFISH_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 2; i++) begin
      key[i] = '0; tweak[i] = '0; blk[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_strobes", {wr_key, wr_tw, wr_blk}, 0);
    check("rst_err", outErr, 0);
    check("rst_resp", outResp, 0);
    check("rst_core_key", core_key, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests, four grants in a row
    key[0] = {16{32'h1111_0000}}; tweak[0] = {4{32'h0000_0001}}; blk[0] = {16{32'h0A0A_0A0A}};
    key[1] = {16{32'h2222_0000}}; tweak[1] = {4{32'h0000_0002}}; blk[1] = {16{32'h0B0B_0B0B}};
    busy_len = 3;
    resp_ready = 2'b11;
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_grant(100, g);
      check($sformatf("sim_grant%0d", n), g, exp_g[n]);
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (12) @(negedge clk);
    resp_ready = 2'b00;

    // Single req0, 72-cycle busy, response held for 20 cycles
    sc0 = strobe_cnt;
    run_op(0, {16{32'hDEAD_BEEF}}, {4{32'h0123_4567}}, {16{32'h89AB_CDEF}}, 72, 1'b1, r, lat);
    check("lat_75", lat, 75);
    check("resp_data0", r, core_f({16{32'hDEAD_BEEF}}, {4{32'h0123_4567}}, {16{32'h89AB_CDEF}}));
    check("one_strobe", strobe_cnt - sc0, 1);
    held = outResp;
    key[1] = {16{32'h5555_AAAA}}; tweak[1] = {4{32'hFEED_0001}}; blk[1] = {16{32'h3C3C_C3C3}};
    req_valid[1] = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (outResp !== held || req_ready[1] !== 1'b0 || resp_valid !== 2'b01) bad = 1'b1;
    end
    check("resp_hold_no_ready1", bad, 0);
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    check("resp_drop", resp_valid, 0);
    run_op(1, {16{32'h5555_AAAA}}, {4{32'hFEED_0001}}, {16{32'h3C3C_C3C3}}, 4, 1'b0, r, lat);
    check("resp_data1", r, core_f({16{32'h5555_AAAA}}, {4{32'hFEED_0001}}, {16{32'h3C3C_C3C3}}));
    check("lat_7", lat, 7);
    repeat (3) @(negedge clk);

    // Core never raises busy
    no_busy = 1'b1;
    req_valid[0] = 1'b1;
    resp_ready[0] = 1'b1;
    wait_grant(50, g);
    check("to_grant", g, 0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("to_strobe", wr_key, 1);
    bad = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00) bad = 1'b1;
      if (k == 15) check("to_err_early", outErr, 0);
      if (k == 16) check("to_err_set", outErr, 1);
    end
    check("to_no_resp", bad, 0);
    resp_ready[0] = 1'b0;
    no_busy = 1'b0;
    run_op(1, {16{32'h0F0F_0F0F}}, {4{32'h7777_7777}}, {16{32'h1234_5678}}, 2, 1'b0, r, lat);
    check("to_next_resp", r, core_f({16{32'h0F0F_0F0F}}, {4{32'h7777_7777}}, {16{32'h1234_5678}}));
    check("err_sticky", outErr, 1);

    // Reset during WAIT_DONE
    key[0] = {16{32'hCAFE_F00D}}; tweak[0] = {4{32'h1357_9BDF}}; blk[0] = {16{32'h2468_ACE0}};
    busy_len = 30;
    req_valid[0] = 1'b1;
    wait_grant(50, g);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_strobes", {wr_key, wr_tw, wr_blk}, 0);
    check("mid_rst_err", outErr, 0);
    check("mid_rst_resp", outResp, 0);
    check("mid_rst_core_ops", {core_key, core_tweak, core_blk}, 0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    run_op(0, {16{32'hCAFE_F00D}}, {4{32'h1357_9BDF}}, {16{32'h2468_ACE0}}, 5, 1'b0, r, lat);
    check("post_rst_resp", r, core_f({16{32'hCAFE_F00D}}, {4{32'h1357_9BDF}}, {16{32'h2468_ACE0}}));

    // Chain of 11 operations fed back through inBlock0
    cur = {16{32'h0000_0001}};
    exp = {16{32'h0000_0001}};
    for (int i = 0; i < 11; i++)
      exp = core_f({16{32'h9E37_79B9}}, {4{32'h7F4A_7C15}}, exp);
    for (int i = 0; i < 11; i++) begin
      run_op(0, {16{32'h9E37_79B9}}, {4{32'h7F4A_7C15}}, cur, 2, 1'b0, r, lat);
      cur = r;
    end
    check("chain11", cur, exp);
    check("strobe_triple_aligned", strobe_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/threefish_arbiter.md
THREEFISH_ARBITER -- requirements
Module: threefish_arbiter

Interface
REQ-001 SHALL have parameter BUSY_WAIT_MAX, default 15, max cycles from write pulse to core busy rise before timeout.
REQ-002 SHALL have parameter NREQ, default 2, number of requesters (only 2 supported).
REQ-003 SHALL have port inClk  in  1  single clock, rising edge.
REQ-004 SHALL have port inRstN  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports inReqValid0/1  in  1  requester N has an operation pending.
REQ-006 SHALL have ports outReqReady0/1  out  1  requester N operands accepted this cycle.
REQ-007 SHALL have ports inKey0/1  in  512, inTweak0/1  in  128, inBlock0/1  in  512  requester N operands.
REQ-008 SHALL have ports outRespValid0/1  out  1, inRespReady0/1  in  1  per-requester result handshake.
REQ-009 SHALL have port outResp  out  512  result block, valid with the asserted outRespValidN.
REQ-010 SHALL have ports outCoreKeyWr, outCoreTweakWr, outCoreBlockWr  out  1  core write strobes.
REQ-011 SHALL have ports outCoreKey  out  512, outCoreTweak  out  128, outCoreBlock  out  512  core operands.
REQ-012 SHALL have ports inCoreBlock  in  512, inCoreBusy  in  1  core result and busy.
REQ-013 SHALL have port outErr  out  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> RESP -> IDLE.
REQ-015 In IDLE, SHALL grant one valid requester, assert its outReqReady for exactly that cycle, register its key/tweak/block and grant ID, go to ISSUE.
REQ-016 SHALL assert outReqReady only in IDLE and only to the granted requester; never both.
REQ-017 In ISSUE, SHALL pulse all three core write strobes high for exactly one cycle with registered operands, then enter WAIT_START.
REQ-018 In WAIT_START, SHALL go to WAIT_DONE on inCoreBusy=1; counter reaching BUSY_WAIT_MAX without busy SHALL set outErr and return to IDLE with no response.
REQ-019 In WAIT_DONE, SHALL go to RESP on the first cycle inCoreBusy=0, capturing inCoreBlock into outResp that edge.
REQ-020 In RESP, SHALL hold outRespValidN (granted N) and outResp stable until inRespReadyN=1, then go to IDLE; the other requester is not served meanwhile.
REQ-021 Minimum accept-to-respValid latency SHALL be 3 cycles plus core busy duration.
REQ-022 Operands on outCoreKey/Tweak/Block SHALL stay stable from ISSUE until leaving WAIT_DONE.
REQ-023 A requester dropping inReqValid before being granted SHALL be permitted; no request is latched without outReqReady.
REQ-024 outErr SHALL clear only on reset.

Reset
REQ-025 On inRstN=0, SHALL asynchronously enter IDLE; all ready, valid, strobe and outErr outputs 0; outResp and core operand outputs 0; priority pointer to requester 0.
REQ-026 Reset mid-operation SHALL abandon the operation without response; the core is not notified.

Configuration
REQ-027 With THREEFISH_ARB_RR_EN defined, SHALL round-robin: after a grant to N, requester 1-N has priority on the next simultaneous request.
REQ-028 Without THREEFISH_ARB_RR_EN, requester 0 SHALL always win simultaneous requests.

Structure
REQ-029 Package threefish_pkg SHALL hold KEY_W=512, TWEAK_W=128, BLK_W=512 and the FSM state enum.
REQ-030 Grant logic SHALL be sub-module threefish_arb_grant (inputs 2 valids + pointer, output one-hot grant).

Verification
REQ-031 Single req0, core model busy 72 cycles -> one 1-cycle strobe triple, outRespValid0 after busy falls, outResp = model output.
REQ-032 Simultaneous req0/req1 repeated 4 times, RR_EN -> grants 0,1,0,1; without -> 0,0,0,0 while req0 held.
REQ-033 Core never raises busy, BUSY_WAIT_MAX=15 -> outErr=1 by cycle 17 after strobe, FSM IDLE, no respValid.
REQ-034 inRespReady0 held 0 for 20 cycles in RESP -> outResp stable, outReqReady1 stays 0 despite inReqValid1=1.
REQ-035 inRstN low during WAIT_DONE -> all outputs 0 immediately, next request served normally.
REQ-036 Chain 11 operations feeding outResp back as inBlock0 -> final outResp equals 11-fold core model result.
